// File: rtl/ct_idu_rf_ereg_acc_if.sv
// Flag delivery bundle between the ereg entries, this accumulator and CP0.
// The slave side is the accumulator; the master side is its environment.
interface ct_idu_rf_ereg_acc_if #(
  parameter int NUM_EREG = 32,
  parameter int FLAG_W   = 6
);
  logic [NUM_EREG*FLAG_W-1:0] ereg_acc_dout;
  logic                       cp0_idu_ereg_ack;
  logic                       cp0_idu_ereg_drain_req;
  logic                       idu_cp0_ereg_vld;
  logic [FLAG_W-1:0]          idu_cp0_ereg_data;
  logic                       idu_cp0_ereg_drained;

  modport slave (
    input  ereg_acc_dout,
    input  cp0_idu_ereg_ack,
    input  cp0_idu_ereg_drain_req,
    output idu_cp0_ereg_vld,
    output idu_cp0_ereg_data,
    output idu_cp0_ereg_drained
  );

  modport master (
    output ereg_acc_dout,
    output cp0_idu_ereg_ack,
    output cp0_idu_ereg_drain_req,
    input  idu_cp0_ereg_vld,
    input  idu_cp0_ereg_data,
    input  idu_cp0_ereg_drained
  );
endinterface

// File: rtl/ct_idu_rf_ereg_acc.sv
// Ereg exception-flag accumulator: OR-reduces retired entry flags and hands them
// to CP0 over a valid/ack handshake, with a drain indication for CSR reads.

module gated_clk_cell (
  input  logic clk_in,
  input  logic global_en,
  input  logic module_en,
  input  logic local_en,
  input  logic external_en,
  input  logic pad_yy_icg_scan_en,
  output logic clk_out
);
  logic clk_en_s;
  logic clk_en_lat;

  assign clk_en_s = (global_en & (module_en | local_en)) | external_en;

  // Enable latch is transparent while the clock is low so clk_out never glitches.
  always_latch begin
    if (!clk_in) begin
      clk_en_lat <= clk_en_s | pad_yy_icg_scan_en;
    end
  end

  assign clk_out = clk_in & clk_en_lat;
endmodule

module ct_idu_rf_ereg_acc #(
  parameter int NUM_EREG = 32,
  parameter int FLAG_W   = 6
) (
  input  logic                       forever_cpuclk,
  input  logic                       cpurst_b,
  input  logic                       cp0_idu_icg_en,
  input  logic                       cp0_yy_clk_en,
  input  logic                       pad_yy_icg_scan_en,
  ct_idu_rf_ereg_acc_if.slave        ereg_if
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [FLAG_W-1:0]   s1_flags_q;
  logic [FLAG_W-1:0]   pend_q, pend_d;
  logic [FLAG_W-1:0]   data_q, data_d;
  logic                drained_q, drained_d;
  logic [FLAG_W-1:0]   acc_or_s;
  logic [FLAG_W-1:0]   merge_s;
  logic                s1_vld_s;
  logic                local_en_s;
  logic                gated_clk;

  // OR tree across all entry flag words.
  always_comb begin
    acc_or_s = '0;
    for (int i = 0; i < NUM_EREG; i++) begin
      acc_or_s = acc_or_s | ereg_if.ereg_acc_dout[i*FLAG_W +: FLAG_W];
    end
  end

  assign s1_vld_s   = |s1_flags_q;
  assign merge_s    = pend_q | s1_flags_q;
  assign local_en_s = (|acc_or_s) | (|s1_flags_q) | (|pend_q) | (state_q != ST_IDLE);

  gated_clk_cell x_ereg_acc_gated_clk (
    .clk_in             (forever_cpuclk),
    .global_en          (cp0_yy_clk_en),
    .module_en          (cp0_idu_icg_en),
    .local_en           (local_en_s),
    .external_en        (1'b0),
    .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
    .clk_out            (gated_clk)
  );

  // Next-state and payload selection for the delivery FSM.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pend_d  = pend_q;
    case (state_q)
      ST_IDLE: begin
        if (s1_vld_s) begin
          data_d  = s1_flags_q;
          state_d = ST_SEND;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        // New stage-1 flags arriving with the ack go out in the next payload.
        if (!ereg_if.cp0_idu_ereg_ack) begin
          pend_d = merge_s;
        end else if (merge_s != '0) begin
          data_d = merge_s;
          pend_d = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign drained_d = ereg_if.cp0_idu_ereg_drain_req & (state_q == ST_IDLE) & ~s1_vld_s
                   & (pend_q == '0) & (acc_or_s == '0);

  // FSM state and drain status run on the free clock: drained must still follow
  // drain_req while the pipeline is empty and the gated clock is stopped.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q   <= ST_IDLE;
      drained_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drained_q <= drained_d;
    end
  end

  // Flag datapath registers on the gated clock.
  always_ff @(posedge gated_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      s1_flags_q <= '0;
      pend_q     <= '0;
      data_q     <= '0;
    end else begin
      s1_flags_q <= acc_or_s;
      pend_q     <= pend_d;
      data_q     <= data_d;
    end
  end

  assign ereg_if.idu_cp0_ereg_vld     = (state_q == ST_SEND);
  assign ereg_if.idu_cp0_ereg_data    = data_q;
  assign ereg_if.idu_cp0_ereg_drained = drained_q;

endmodule

// File: tb/tb_ct_idu_rf_ereg_acc.sv
// Bench for ct_idu_rf_ereg_acc: directed scenarios plus randomized traffic
// checked against a transaction-level model of flag delivery.
module tb_ct_idu_rf_ereg_acc;
  localparam int NE = 32;
  localparam int FW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic icg_en = 1'b0;
  logic clk_en = 1'b1;
  logic scan_en = 1'b0;
  int checks = 0;
  int errors = 0;

  // Model: stage-1 word, pending word, current payload, valid, drained.
  logic [FW-1:0] m_s1 = '0, m_pend = '0, m_data = '0;
  bit m_vld = 1'b0, m_dr = 1'b0;

  ct_idu_rf_ereg_acc_if #(.NUM_EREG(NE), .FLAG_W(FW)) bus ();

  ct_idu_rf_ereg_acc #(.NUM_EREG(NE), .FLAG_W(FW)) dut (
    .forever_cpuclk     (clk),
    .cpurst_b           (rst_n),
    .cp0_idu_icg_en     (icg_en),
    .cp0_yy_clk_en      (clk_en),
    .pad_yy_icg_scan_en (scan_en),
    .ereg_if            (bus)
  );

  always #5 clk = ~clk;

  task automatic set_entry(input int idx, input logic [FW-1:0] v);
    bus.ereg_acc_dout[idx*FW +: FW] = v;
  endtask

  task automatic clr_inputs();
    bus.ereg_acc_dout = '0;
    bus.cp0_idu_ereg_ack = 1'b0;
  endtask

  // One clock edge; the model advances from the inputs present at that edge.
  task automatic tick();
    logic [FW-1:0] acc, mrg, n_data, n_pend;
    bit n_vld, n_dr;
    acc = '0;
    for (int i = 0; i < NE; i++) acc = acc | bus.ereg_acc_dout[i*FW +: FW];
    mrg = m_pend | m_s1;
    n_dr = bus.cp0_idu_ereg_drain_req && !m_vld && (m_s1 == '0) && (m_pend == '0) && (acc == '0);
    n_vld = m_vld; n_data = m_data; n_pend = m_pend;
    if (!m_vld) begin
      if (m_s1 != '0) begin n_vld = 1'b1; n_data = m_s1; end
    end else if (!bus.cp0_idu_ereg_ack) begin
      n_pend = mrg;
    end else if (mrg != '0) begin
      n_data = mrg; n_pend = '0;
    end else begin
      n_vld = 1'b0;
    end
    @(posedge clk); #1;
    m_s1 = acc; m_pend = n_pend; m_data = n_data; m_vld = n_vld; m_dr = n_dr;
  endtask

  task automatic model_reset();
    m_s1 = '0; m_pend = '0; m_data = '0; m_vld = 1'b0; m_dr = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks += 3;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_data !== 6'b000000) begin errors++; $display("FAIL reset_data: got %b want 000000", bus.idu_cp0_ereg_data); end
    if (bus.idu_cp0_ereg_drained !== 1'b0) begin errors++; $display("FAIL reset_drained: got %b want 0", bus.idu_cp0_ereg_drained); end
    #11 rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL post_reset_vld: got %b want 0", bus.idu_cp0_ereg_vld); end
  endtask

  task automatic test_single_flag();
    set_entry(3, 6'b000001);
    tick();
    clr_inputs();
    checks++;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL single_t1_vld: got %b want 0", bus.idu_cp0_ereg_vld); end
    tick();
    checks += 2;
    if (bus.idu_cp0_ereg_vld !== 1'b1) begin errors++; $display("FAIL single_t2_vld: got %b want 1", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_data !== 6'b000001) begin errors++; $display("FAIL single_data: got %b want 000001", bus.idu_cp0_ereg_data); end
    bus.cp0_idu_ereg_ack = 1'b1;
    tick();
    bus.cp0_idu_ereg_ack = 1'b0;
    checks++;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL single_ack_idle: got %b want 0", bus.idu_cp0_ereg_vld); end
  endtask

  task automatic test_multi_entry();
    set_entry(0, 6'b000100);
    set_entry(31, 6'b100000);
    tick();
    clr_inputs();
    tick();
    checks += 2;
    if (bus.idu_cp0_ereg_vld !== 1'b1) begin errors++; $display("FAIL multi_vld: got %b want 1", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_data !== 6'b100100) begin errors++; $display("FAIL multi_data: got %b want 100100", bus.idu_cp0_ereg_data); end
    bus.cp0_idu_ereg_ack = 1'b1;
    tick();
    bus.cp0_idu_ereg_ack = 1'b0;
    checks++;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL multi_single_delivery: got %b want 0", bus.idu_cp0_ereg_vld); end
  endtask

  task automatic test_backpressure();
    set_entry(5, 6'b000001); tick();
    clr_inputs(); set_entry(9, 6'b000010); tick();
    clr_inputs(); set_entry(9, 6'b000010); tick();
    clr_inputs(); tick(); tick();
    checks += 2;
    if (bus.idu_cp0_ereg_vld !== 1'b1) begin errors++; $display("FAIL bp_hold_vld: got %b want 1", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_data !== 6'b000001) begin errors++; $display("FAIL bp_hold_data: got %b want 000001", bus.idu_cp0_ereg_data); end
    bus.cp0_idu_ereg_ack = 1'b1;
    tick();
    bus.cp0_idu_ereg_ack = 1'b0;
    checks += 2;
    if (bus.idu_cp0_ereg_vld !== 1'b1) begin errors++; $display("FAIL bp_second_vld: got %b want 1", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_data !== 6'b000010) begin errors++; $display("FAIL bp_second_data: got %b want 000010", bus.idu_cp0_ereg_data); end
    bus.cp0_idu_ereg_ack = 1'b1;
    tick();
    bus.cp0_idu_ereg_ack = 1'b0;
    checks++;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL bp_final_idle: got %b want 0", bus.idu_cp0_ereg_vld); end
  endtask

  task automatic test_ack_coincident();
    set_entry(1, 6'b000001); tick();
    clr_inputs(); set_entry(2, 6'b001000); tick();
    clr_inputs(); tick();
    set_entry(7, 6'b010000); tick();
    clr_inputs(); bus.cp0_idu_ereg_ack = 1'b1; tick();
    bus.cp0_idu_ereg_ack = 1'b0;
    checks += 2;
    if (bus.idu_cp0_ereg_vld !== 1'b1) begin errors++; $display("FAIL coinc_vld: got %b want 1", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_data !== 6'b011000) begin errors++; $display("FAIL coinc_data: got %b want 011000", bus.idu_cp0_ereg_data); end
    bus.cp0_idu_ereg_ack = 1'b1; tick();
    bus.cp0_idu_ereg_ack = 1'b0;
    checks++;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL coinc_no_resend: got %b want 0", bus.idu_cp0_ereg_vld); end
  endtask

  task automatic test_drain();
    bus.cp0_idu_ereg_drain_req = 1'b1;
    set_entry(12, 6'b000010); tick();
    clr_inputs(); tick();
    checks += 2;
    if (bus.idu_cp0_ereg_vld !== 1'b1) begin errors++; $display("FAIL drain_send_vld: got %b want 1", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_drained !== 1'b0) begin errors++; $display("FAIL drain_in_send: got %b want 0", bus.idu_cp0_ereg_drained); end
    bus.cp0_idu_ereg_ack = 1'b1; tick();
    bus.cp0_idu_ereg_ack = 1'b0;
    checks++;
    if (bus.idu_cp0_ereg_drained !== 1'b0) begin errors++; $display("FAIL drain_ack_cycle: got %b want 0", bus.idu_cp0_ereg_drained); end
    tick();
    checks++;
    if (bus.idu_cp0_ereg_drained !== 1'b1) begin errors++; $display("FAIL drain_done: got %b want 1", bus.idu_cp0_ereg_drained); end
    bus.cp0_idu_ereg_drain_req = 1'b0; tick();
    checks++;
    if (bus.idu_cp0_ereg_drained !== 1'b0) begin errors++; $display("FAIL drain_release: got %b want 0", bus.idu_cp0_ereg_drained); end
  endtask

  task automatic test_random();
    logic [FW-1:0] injected, delivered, v;
    int idx;
    injected = '0; delivered = '0;
    for (int c = 0; c < 400; c++) begin
      bus.ereg_acc_dout = '0;
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          idx = int'($urandom_range(0, NE - 1));
          v = FW'($urandom_range(1, 63));
          set_entry(idx, v);
          injected = injected | v;
        end
      end
      bus.cp0_idu_ereg_ack = 1'($urandom_range(0, 1));
      bus.cp0_idu_ereg_drain_req = ($urandom_range(0, 2) != 0);
      icg_en = 1'($urandom_range(0, 1));
      if (m_vld && bus.cp0_idu_ereg_ack) delivered = delivered | m_data;
      tick();
      checks += 3;
      if (bus.idu_cp0_ereg_vld !== m_vld) begin errors++; $display("FAIL rand_vld c=%0d: got %b want %b", c, bus.idu_cp0_ereg_vld, m_vld); end
      if (m_vld && bus.idu_cp0_ereg_data !== m_data) begin errors++; $display("FAIL rand_data c=%0d: got %b want %b", c, bus.idu_cp0_ereg_data, m_data); end
      if (bus.idu_cp0_ereg_drained !== m_dr) begin errors++; $display("FAIL rand_drained c=%0d: got %b want %b", c, bus.idu_cp0_ereg_drained, m_dr); end
    end
    bus.ereg_acc_dout = '0; bus.cp0_idu_ereg_drain_req = 1'b0; icg_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.cp0_idu_ereg_ack = 1'b1;
      if (m_vld) delivered = delivered | bus.idu_cp0_ereg_data;
      tick();
    end
    bus.cp0_idu_ereg_ack = 1'b0;
    checks += 2;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL rand_flush_idle: got %b want 0", bus.idu_cp0_ereg_vld); end
    if (delivered !== injected) begin errors++; $display("FAIL rand_conservation: got %b want %b", delivered, injected); end
  endtask

  task automatic test_async_reset();
    bus.cp0_idu_ereg_drain_req = 1'b1;
    set_entry(4, 6'b000001); tick();
    clr_inputs(); set_entry(20, 6'b111111); tick();
    clr_inputs(); tick();
    checks++;
    if (bus.idu_cp0_ereg_vld !== 1'b1) begin errors++; $display("FAIL arst_pre_vld: got %b want 1", bus.idu_cp0_ereg_vld); end
    #2 rst_n = 1'b0;
    #1;
    checks += 3;
    if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL arst_vld: got %b want 0", bus.idu_cp0_ereg_vld); end
    if (bus.idu_cp0_ereg_data !== 6'b000000) begin errors++; $display("FAIL arst_data: got %b want 000000", bus.idu_cp0_ereg_data); end
    if (bus.idu_cp0_ereg_drained !== 1'b0) begin errors++; $display("FAIL arst_drained: got %b want 0", bus.idu_cp0_ereg_drained); end
    bus.cp0_idu_ereg_drain_req = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (bus.idu_cp0_ereg_vld !== 1'b0) begin errors++; $display("FAIL arst_no_delivery c=%0d: got %b want 0", c, bus.idu_cp0_ereg_vld); end
    end
  endtask

  initial begin
    bus.ereg_acc_dout = '0;
    bus.cp0_idu_ereg_ack = 1'b0;
    bus.cp0_idu_ereg_drain_req = 1'b0;
    test_reset();
    test_single_flag();
    test_multi_entry();
    test_backpressure();
    test_ack_coincident();
    test_drain();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
